// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU.
// Grants one operation at a time and rotates priority after each completed response.
module alu_arbiter #(
    parameter int unsigned NB_OP = 6,
    parameter int unsigned NB_AB = 4
) (
    input  logic                 clock,
    input  logic                 i_reset,
    input  logic [1:0]           i_req_valid,
    output logic [1:0]           o_req_ready,
    input  logic [2*NB_OP-1:0]   i_req_op,
    input  logic [2*NB_AB-1:0]   i_req_a,
    input  logic [2*NB_AB-1:0]   i_req_b,
    output logic [1:0]           o_rsp_valid,
    input  logic [1:0]           i_rsp_ready,
    output logic [NB_AB-1:0]     o_rsp_data,
    output logic [NB_OP-1:0]     o_alu_op,
    output logic [NB_AB-1:0]     o_alu_a,
    output logic [NB_AB-1:0]     o_alu_b,
    input  logic [NB_AB-1:0]     i_alu_result,
    output logic                 o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic               gnt_q, gnt_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic [NB_AB-1:0]   a_q, a_d;
    logic [NB_AB-1:0]   b_q, b_d;
    logic [NB_AB-1:0]   res_q, res_d;

    logic               win_valid;
    logic               win_id;

    // Combinational grant, only offered while idle; pointer breaks ties
    always_comb begin
        win_valid = 1'b0;
        win_id    = ptr_q;
        if (state_q == IDLE) begin
            case (i_req_valid)
                2'b01:   begin win_valid = 1'b1; win_id = 1'b0;  end
                2'b10:   begin win_valid = 1'b1; win_id = 1'b1;  end
                2'b11:   begin win_valid = 1'b1; win_id = ptr_q; end
                default: begin win_valid = 1'b0; win_id = ptr_q; end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                // The winner's valid is high by construction, so a grant is a handshake
                if (win_valid) begin
                    gnt_d   = win_id;
                    op_d    = win_id ? i_req_op[2*NB_OP-1:NB_OP] : i_req_op[NB_OP-1:0];
                    a_d     = win_id ? i_req_a[2*NB_AB-1:NB_AB]  : i_req_a[NB_AB-1:0];
                    b_d     = win_id ? i_req_b[2*NB_AB-1:NB_AB]  : i_req_b[NB_AB-1:0];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = i_alu_result;
                state_d = RESP;
            end
            RESP: begin
                if (i_rsp_ready[gnt_q]) begin
                    ptr_d   = ~gnt_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            gnt_q   <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    assign o_req_ready = {win_valid & win_id, win_valid & ~win_id};
    assign o_rsp_valid = (state_q == RESP) ? {gnt_q, ~gnt_q} : 2'b00;
    assign o_rsp_data  = res_q;
    assign o_alu_op    = op_q;
    assign o_alu_a     = a_q;
    assign o_alu_b     = b_q;
    assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter with a queue-based scoreboard
// and a cycle-phase reference model driven from the request rules.
module tb_alu_arbiter;

    localparam int unsigned NB_OP = 6;
    localparam int unsigned NB_AB = 4;

    logic                clock;
    logic                i_reset;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*NB_OP-1:0]  req_op;
    logic [2*NB_AB-1:0]  req_a;
    logic [2*NB_AB-1:0]  req_b;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [NB_AB-1:0]    rsp_data;
    logic [NB_OP-1:0]    alu_op;
    logic [NB_AB-1:0]    alu_a;
    logic [NB_AB-1:0]    alu_b;
    logic [NB_AB-1:0]    alu_result;
    logic                busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic             id;
        logic [NB_OP-1:0] op;
        logic [NB_AB-1:0] a;
        logic [NB_AB-1:0] b;
        logic [NB_AB-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   m_phase = 0;
    logic m_ptr   = 1'b0;

    alu_arbiter #(.NB_OP(NB_OP), .NB_AB(NB_AB)) dut (
        .clock        (clock),
        .i_reset      (i_reset),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_op     (req_op),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_data   (rsp_data),
        .o_alu_op     (alu_op),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .i_alu_result (alu_result),
        .o_busy       (busy)
    );

    // ALU stub: modular addition of the operands
    assign alu_result = alu_a + alu_b;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] winner(input logic [1:0] v, input logic p);
        return (v == 2'b11) ? (p ? 2'b10 : 2'b01) : v;
    endfunction

    // Monitor: reference model advances on the falling edge, when inputs are stable
    always @(negedge clock) begin
        if (!i_reset) begin
            exp_q.delete();
            m_phase = 0;
            m_ptr   = 1'b0;
            chk("rst_alu",   32'({alu_op, alu_a, alu_b}), 32'd0);
            chk("rst_rsp",   32'({rsp_valid, rsp_data, busy}), 32'd0);
            chk("rst_ready", 32'(req_ready), 32'(winner(req_valid, 1'b0)));
        end else begin
            case (m_phase)
                0: begin
                    logic [1:0] w;
                    exp_t       e;
                    w = winner(req_valid, m_ptr);
                    chk("idle_ready", 32'(req_ready), 32'(w));
                    chk("idle_rsp",   32'({rsp_valid, busy}), 32'd0);
                    if (w != 2'b00) begin
                        e.id   = w[1];
                        e.op   = e.id ? req_op[2*NB_OP-1:NB_OP] : req_op[NB_OP-1:0];
                        e.a    = e.id ? req_a[2*NB_AB-1:NB_AB]  : req_a[NB_AB-1:0];
                        e.b    = e.id ? req_b[2*NB_AB-1:NB_AB]  : req_b[NB_AB-1:0];
                        e.data = NB_AB'((int'(e.a) + int'(e.b)) % (1 << NB_AB));
                        exp_q.push_back(e);
                        m_phase = 1;
                    end
                end
                1: begin
                    chk("exec_ctl", 32'({req_ready, rsp_valid, busy}), 32'd1);
                    chk("exec_alu", 32'({alu_op, alu_a, alu_b}),
                        32'({exp_q[0].op, exp_q[0].a, exp_q[0].b}));
                    m_phase = 2;
                end
                default: begin
                    chk("resp_ctl",   32'({req_ready, busy}), 32'd1);
                    chk("resp_valid", 32'(rsp_valid), exp_q[0].id ? 32'd2 : 32'd1);
                    chk("resp_data",  32'(rsp_data), 32'(exp_q[0].data));
                    if (rsp_ready[exp_q[0].id]) begin
                        m_ptr   = ~exp_q[0].id;
                        m_phase = 0;
                        void'(exp_q.pop_front());
                    end
                end
            endcase
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic drain;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (4) step();
    endtask

    task automatic pulse_reset;
        req_valid = 2'b00;
        i_reset   = 1'b0;
        step();
        i_reset   = 1'b1;
    endtask

    initial begin
        i_reset   = 1'b0;
        req_valid = 2'b00;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 2'b00;
        #1;
        chk("init_busy", 32'(busy), 32'd0);
        repeat (2) step();
        i_reset = 1'b1;
        step();

        // Single request from R0
        req_valid = 2'b01;
        req_op    = {6'd0, 6'b100000};
        req_a     = {4'd0, 4'd3};
        req_b     = {4'd0, 4'd4};
        rsp_ready = 2'b11;
        #1;
        chk("single_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 2'b00;
        chk("single_alu", 32'({alu_op, alu_a, alu_b}), 32'({6'b100000, 4'd3, 4'd4}));
        step();
        chk("single_rsp", 32'({rsp_valid, rsp_data}), 32'({2'b01, 4'd7}));
        step();
        chk("single_idle", 32'(busy), 32'd0);
        drain();

        // Contention: alternating grants after reset
        pulse_reset();
        req_valid = 2'b11;
        req_op    = 12'($urandom);
        req_a     = 8'($urandom);
        req_b     = 8'($urandom);
        rsp_ready = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            int n = 0;
            while (req_ready == 2'b00 && n < 10) begin
                step();
                n++;
            end
            chk("contend_gnt", 32'(req_ready), (k % 2 == 1) ? 32'd2 : 32'd1);
            step();
        end
        drain();

        // Backpressure on an R1 response
        req_valid = 2'b10;
        req_a     = {4'd9, 4'd0};
        req_b     = {4'd9, 4'd0};
        rsp_ready = 2'b00;
        step();
        req_valid = 2'b11;
        step();
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp",  32'({rsp_valid, rsp_data}), 32'({2'b10, 4'd2}));
            chk("bp_ctl",  32'({req_ready, busy}), 32'd1);
            step();
        end
        req_valid = 2'b00;
        rsp_ready = 2'b10;
        step();
        chk("bp_done", 32'(busy), 32'd0);
        drain();

        // Ready from the wrong requester is ignored
        req_valid = 2'b01;
        req_a     = 8'($urandom);
        req_b     = 8'($urandom);
        rsp_ready = 2'b10;
        step();
        req_valid = 2'b00;
        step();
        repeat (3) begin
            step();
            chk("wrong_ready_hold", 32'(rsp_valid), 32'd1);
        end
        rsp_ready = 2'b01;
        step();
        chk("wrong_ready_done", 32'(busy), 32'd0);
        drain();

        // Asynchronous reset while a response is pending
        req_valid = 2'b01;
        req_a     = 8'($urandom);
        req_b     = 8'($urandom);
        rsp_ready = 2'b00;
        step();
        req_valid = 2'b11;
        step();
        chk("midrst_pre", 32'(busy), 32'd1);
        i_reset = 1'b0;
        #1;
        chk("midrst_rsp",   32'({rsp_valid, rsp_data, busy}), 32'd0);
        chk("midrst_alu",   32'({alu_op, alu_a, alu_b}), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd1);
        req_valid = 2'b00;
        step();
        i_reset   = 1'b1;
        req_valid = 2'b10;
        req_a     = 8'($urandom);
        req_b     = 8'($urandom);
        rsp_ready = 2'b10;
        step();
        req_valid = 2'b00;
        repeat (2) step();
        chk("midrst_after", 32'(busy), 32'd0);
        drain();

        // R1 request withdrawn while R0 executes
        req_valid = 2'b01;
        rsp_ready = 2'b01;
        step();
        req_valid = 2'b10;
        step();
        req_valid = 2'b00;
        repeat (4) begin
            step();
            chk("withdrawn_ready", 32'(req_ready), 32'd0);
        end
        drain();

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            req_valid = 2'($urandom_range(0, 3));
            req_op    = 12'($urandom);
            req_a     = 8'($urandom);
            req_b     = 8'($urandom);
            rsp_ready = 2'($urandom_range(0, 3));
            step();
        end
        drain();
        chk("final_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter NB_OP, default 6, meaning operation code width.
REQ-002 The block SHALL have parameter NB_AB, default 4, meaning operand and result width.
REQ-003 The block SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_reset, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port i_req_valid, input, 2 bits, request valid per requester (bit 0 = R0, bit 1 = R1).
REQ-006 The block SHALL have port o_req_ready, output, 2 bits, request accept per requester.
REQ-007 The block SHALL have port i_req_op, input, 2*NB_OP bits, per-requester op code (R0 in low NB_OP bits).
REQ-008 The block SHALL have ports i_req_a and i_req_b, input, 2*NB_AB bits each, per-requester operands (R0 in low bits).
REQ-009 The block SHALL have port o_rsp_valid, output, 2 bits, response valid per requester.
REQ-010 The block SHALL have port i_rsp_ready, input, 2 bits, response accept per requester.
REQ-011 The block SHALL have port o_rsp_data, output, NB_AB bits, result for the requester flagged in o_rsp_valid.
REQ-012 The block SHALL have ports o_alu_op (NB_OP), o_alu_a (NB_AB), o_alu_b (NB_AB), outputs, driving the shared combinational ALU.
REQ-013 The block SHALL have port i_alu_result, input, NB_AB bits, ALU result.
REQ-014 The block SHALL have port o_busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-015 The block SHALL implement FSM states IDLE, EXEC, RESP.
REQ-016 In IDLE, the grant SHALL be combinational: if exactly one i_req_valid bit is high, that requester wins; if both are high, the requester indicated by the priority pointer wins; otherwise there is no winner.
REQ-017 o_req_ready SHALL be one-hot for the winner in IDLE and all-zero in EXEC and RESP.
REQ-018 On a clock edge with i_req_valid[g] and o_req_ready[g] both high, the block SHALL register op/a/b of requester g and grant id g, and go to EXEC.
REQ-019 o_alu_op/o_alu_a/o_alu_b SHALL always be driven from the registered op/a/b, which hold their value outside a request handshake.
REQ-020 From EXEC, at the next edge the block SHALL capture i_alu_result into the result register and go to RESP.
REQ-021 In RESP, o_rsp_valid SHALL be one-hot on the granted id, o_rsp_data SHALL equal the result register, and both SHALL hold stable until i_rsp_ready[g] is sampled high.
REQ-022 On a clock edge with i_rsp_ready[g] sampled high in RESP, the block SHALL go to IDLE and set the priority pointer to the other requester.
REQ-023 i_rsp_ready of the non-granted requester SHALL be ignored.
REQ-024 Latency SHALL be: accept edge T0, result capture at edge T0+1, o_rsp_valid high from T0+1; peak throughput one operation per 3 cycles.
REQ-025 A requester dropping i_req_valid before acceptance SHALL cause no state change; the block SHALL not modify or check op code content.
REQ-026 o_rsp_valid and o_req_ready SHALL never be high in the same cycle.

Reset
REQ-027 While i_reset is low, asynchronously: state = IDLE, priority pointer = R0, op/a/b/result registers = 0; hence o_alu_* = 0, o_rsp_data = 0, o_rsp_valid = 0, o_busy = 0, o_req_ready = i_req_valid winner under pointer R0.
REQ-028 Reset asserted in EXEC or RESP SHALL discard the operation and its pending response; the requester re-issues it.

Verification (bench stub drives i_alu_result = (o_alu_a + o_alu_b) mod 2^NB_AB)
REQ-029 The bench SHALL cover single request: R0 sends op=6'b100000, a=3, b=4, rsp_ready=1 -> o_req_ready=2'b01 in the same cycle, o_alu_a=3 and o_alu_b=4 after T0, o_rsp_valid=2'b01 and o_rsp_data=7 from T0+1, IDLE at T0+2.
REQ-030 The bench SHALL cover contention: both valid continuously after reset -> grants R0, R1, R0, R1 in turn, each responding on its own o_rsp_valid bit.
REQ-031 The bench SHALL cover backpressure: R1 request a=9, b=9, i_rsp_ready low for 5 cycles -> o_rsp_valid=2'b10 and o_rsp_data=2 stay stable, o_req_ready=0 and o_busy=1 throughout.
REQ-032 The bench SHALL cover wrong-ready: R0 in RESP with i_rsp_ready=2'b10 -> no transition; 2'b01 -> IDLE.
REQ-033 The bench SHALL cover mid-operation reset: i_reset low during RESP -> all outputs at their reset values immediately, without waiting for a clock edge; after release a new R1 request completes normally.
REQ-034 The bench SHALL cover the withdrawn request: R1 valid for one cycle while in EXEC, then dropped -> R1 never granted.
